// File: rtl/serial_csa_adder.sv
// Multi-cycle WIDTH-bit adder: two bits per cycle through a carry-select slice.
// Optional signed-overflow output is enabled by defining SERIAL_CSA_OVF_EN.
module serial_csa_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_CSA_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] opa_sh;
    logic [WIDTH-1:0] opb_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last;
    logic [1:0]       a2;
    logic [1:0]       b2;
    logic [2:0]       sel0;
    logic [2:0]       sel1;
    logic [1:0]       slice_s;
    logic             slice_c;
    logic [WIDTH+1:0] res_cat;
    logic [WIDTH-1:0] res_next;
`ifdef SERIAL_CSA_OVF_EN
    logic             msb_cin;
`endif

    assign accept = start && (state != RUN);
    assign last   = (cnt == CW'(N - 1));
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last) next_state = DONE;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Both carry hypotheses are formed up front; the registered carry picks one.
    always_comb begin
        a2       = opa_sh[1:0];
        b2       = opb_sh[1:0];
        sel0     = {1'b0, a2} + {1'b0, b2};
        sel1     = sel0 + 3'd1;
        {slice_c, slice_s} = carry ? sel1 : sel0;
        res_cat  = {slice_s, res_sh};
        res_next = res_cat[WIDTH+1:2];
`ifdef SERIAL_CSA_OVF_EN
        msb_cin  = carry ? (a2[0] | b2[0]) : (a2[0] & b2[0]);
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            opa_sh <= '0;
            opb_sh <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_CSA_OVF_EN
            ovf    <= 1'b0;
`endif
        end else if (accept) begin
            opa_sh <= op_a;
            opb_sh <= op_b;
            res_sh <= '0;
            carry  <= cin;
            cnt    <= '0;
        end else if (state == RUN) begin
            opa_sh <= opa_sh >> 2;
            opb_sh <= opb_sh >> 2;
            res_sh <= res_next;
            carry  <= slice_c;
            cnt    <= cnt + CW'(1);
            // Outputs move only on the completing edge so they hold through RUN.
            if (last) begin
                sum  <= res_next;
                cout <= slice_c;
`ifdef SERIAL_CSA_OVF_EN
                ovf  <= msb_cin ^ slice_c;
`endif
            end
        end
    end

endmodule
